// File: rtl/decoder_if.sv
// Bit-serial link between the serial receiver and the parity checker:
// the incoming line bit plus the forwarded data bit and frame error flag.
interface decoder_if;
    logic datain;
    logic data;
    logic res;

    modport master (
        output datain,
        input  data,
        input  res
    );

    modport slave (
        input  datain,
        output data,
        output res
    );
endinterface

// File: rtl/decoder.sv
// Serial parity checker: forwards FRAME_LEN-1 data bits per frame and flags a
// parity error on the edge that samples each frame's trailing parity bit.
module decoder #(
    parameter int FRAME_LEN  = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic     clk,
    input  logic     rst,
    decoder_if.slave bus
);
    localparam int               CNT_W     = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(FRAME_LEN - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_acc;
    logic             r_data;
    logic             r_res;
    logic             w_parity_slot;

    assign w_parity_slot = (r_cnt == LAST_SLOT);

    // NOTE: non-blocking assignments make every branch below read the
    // pre-edge r_acc/r_cnt, so res folds in the parity bit exactly once.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_acc  <= 1'b0;
            r_data <= 1'b0;
            r_res  <= 1'b0;
        end else if (w_parity_slot) begin
            r_res  <= r_acc ^ bus.datain ^ PARITY_ODD;
            r_data <= 1'b0;
            r_acc  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_acc  <= r_acc ^ bus.datain;
            r_data <= bus.datain;
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.data = r_data;
    assign bus.res  = r_res;
endmodule

// File: tb/tb_decoder.sv
// Self-checking bench for decoder: three instances (even/8, odd/8, even/2)
// driven from directed tables, hand sequences and random streams.
module tb_decoder;
    logic       clk = 1'b0;
    logic [2:0] rst_v;
    int         n_pass  = 0;
    int         n_total = 0;

    decoder_if if0 ();
    decoder_if if1 ();
    decoder_if if2 ();

    decoder #(.FRAME_LEN(8), .PARITY_ODD(1'b0)) u_even8 (.clk(clk), .rst(rst_v[0]), .bus(if0));
    decoder #(.FRAME_LEN(8), .PARITY_ODD(1'b1)) u_odd8  (.clk(clk), .rst(rst_v[1]), .bus(if1));
    decoder #(.FRAME_LEN(2), .PARITY_ODD(1'b0)) u_even2 (.clk(clk), .rst(rst_v[2]), .bus(if2));

    always #5 clk = ~clk;

    // Reference model: bits seen since reset and ones in the current frame.
    int m_len [3] = '{8, 8, 2};
    int m_odd [3] = '{0, 1, 0};
    int m_n   [3] = '{0, 0, 0};
    int m_ones[3] = '{0, 0, 0};
    bit m_data[3] = '{1'b0, 1'b0, 1'b0};
    bit m_res [3] = '{1'b0, 1'b0, 1'b0};

    typedef struct {
        logic rst;
        logic din;
        logic e_data;
        logic e_res;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    task automatic model_edge(input int k, input logic r, input logic d);
        if (r) begin
            m_n[k]    = 0;
            m_ones[k] = 0;
            m_data[k] = 1'b0;
            m_res[k]  = 1'b0;
        end else if ((m_n[k] % m_len[k]) == m_len[k] - 1) begin
            m_res[k]  = (((m_ones[k] + int'(d)) % 2) != m_odd[k]);
            m_data[k] = 1'b0;
            m_ones[k] = 0;
            m_n[k]++;
        end else begin
            m_ones[k] += int'(d);
            m_data[k] = d;
            m_n[k]++;
        end
    endtask

    // Drive one clock on all instances, then compare every output to the model.
    task automatic cycle(input logic [2:0] r, input logic [2:0] d, input string tag);
        logic [2:0] a_data;
        logic [2:0] a_res;
        rst_v      = r;
        if0.datain = d[0];
        if1.datain = d[1];
        if2.datain = d[2];
        for (int k = 0; k < 3; k++) model_edge(k, r[k], d[k]);
        @(posedge clk);
        #1;
        a_data = {if2.data, if1.data, if0.data};
        a_res  = {if2.res, if1.res, if0.res};
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s model data[%0d]", tag, k), a_data[k], m_data[k]);
            check($sformatf("%s model res[%0d]", tag, k), a_res[k], m_res[k]);
        end
    endtask

    initial begin
        logic [7:0] fr;

        rst_v      = 3'b111;
        if0.datain = 1'b0;
        if1.datain = 1'b0;
        if2.datain = 1'b0;

        // Reset hold, then two even-parity frames: good (four 1s), bad (three 1s).
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b1};

        for (int i = 0; i < 18; i++) begin
            cycle({2'b11, vecs[i].rst}, {2'b00, vecs[i].din}, "tbl");
            check($sformatf("tbl[%0d] data", i), if0.data, vecs[i].e_data);
            check($sformatf("tbl[%0d] res", i), if0.res, vecs[i].e_res);
        end

        // Reset mid-frame while res=1, then realignment from the first edge after release.
        cycle(3'b110, 3'b001, "mid");
        cycle(3'b110, 3'b000, "mid");
        cycle(3'b110, 3'b001, "mid");
        check("mid pre-rst res", if0.res, 1'b1);
        cycle(3'b111, 3'b001, "mid");
        check("mid rst res", if0.res, 1'b0);
        check("mid rst data", if0.data, 1'b0);
        for (int i = 0; i < 8; i++) cycle(3'b110, 3'b000, "zero");
        check("zero frame res", if0.res, 1'b0);
        fr = 8'b0000_0001;
        for (int i = 0; i < 8; i++) begin
            cycle(3'b110, {2'b00, fr[i]}, "realign");
            if (i == 0) check("realign data bit0", if0.data, 1'b1);
            if (i == 6) check("realign res edge15", if0.res, 1'b0);
        end
        check("realign res edge16", if0.res, 1'b1);
        check("realign data parity", if0.data, 1'b0);

        // Odd parity instance: one 1 + parity 0 is good, two 1s is bad.
        fr = 8'b0000_0001;
        for (int i = 0; i < 8; i++) cycle(3'b101, {1'b0, fr[i], 1'b0}, "odd");
        check("odd good frame res", if1.res, 1'b0);
        fr = 8'b1000_0001;
        for (int i = 0; i < 8; i++) cycle(3'b101, {1'b0, fr[i], 1'b0}, "odd");
        check("odd bad frame res", if1.res, 1'b1);

        // Two-bit frames: stream 1,1,1,0,0,0 -> res 0,1,0 at edges 2,4,6.
        fr = 8'b0000_0111;
        for (int i = 0; i < 6; i++) begin
            cycle(3'b011, {fr[i], 2'b00}, "len2");
            if (i == 1) check("len2 res e2", if2.res, 1'b0);
            if (i == 3) check("len2 res e4", if2.res, 1'b1);
            if (i == 5) check("len2 res e6", if2.res, 1'b0);
            if (i == 2) check("len2 data e3", if2.data, 1'b1);
            if (i == 4) check("len2 data e5", if2.data, 1'b0);
        end

        // Random streams with occasional resets on every instance.
        for (int i = 0; i < 800; i++) begin
            logic [2:0] r;
            for (int k = 0; k < 3; k++) r[k] = ($urandom_range(0, 39) == 0);
            cycle(r, 3'($urandom), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
